// File: rtl/fp32_pkg.sv
// Shared field widths, FSM state encoding and the packed single-precision
// layout used by the sequential fp32 adder.
package fp32_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = 27;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Working mantissa {carry, hidden, frac, guard, sticky}; a zero exponent flushes to zero.
  function automatic logic [MANT_W-1:0] unpack_mant(input fp32_t x);
    if (x.exp == '0) return '0;
    return {2'b01, x.frac, 2'b00};
  endfunction

endpackage

// File: rtl/fp32_unpack.sv
// Combinational operand unpack: flush-to-zero, hidden bit, magnitude compare
// and larger/smaller swap ahead of the sequential datapath.
module fp32_unpack
  import fp32_pkg::*;
(
  input  fp32_t             a,
  input  fp32_t             b,
  output logic              sign_l,
  output logic              sign_s,
  output logic [EXP_W-1:0]  exp_l,
  output logic [EXP_W-1:0]  d,
  output logic [MANT_W-1:0] mant_l,
  output logic [MANT_W-1:0] mant_s
);

  logic [MANT_W-1:0] ma, mb;
  logic              a_large;

  always_comb begin
    ma      = unpack_mant(a);
    mb      = unpack_mant(b);
    // Ties on both exponent and mantissa keep A as the larger operand.
    a_large = (a.exp > b.exp) || ((a.exp == b.exp) && (ma >= mb));
    if (a_large) begin
      sign_l = a.sign;
      sign_s = b.sign;
      exp_l  = a.exp;
      d      = a.exp - b.exp;
      mant_l = ma;
      mant_s = mb;
    end else begin
      sign_l = b.sign;
      sign_s = a.sign;
      exp_l  = b.exp;
      d      = b.exp - a.exp;
      mant_l = mb;
      mant_s = ma;
    end
  end

endmodule

// File: rtl/fp32_add_sequencer.sv
// Multi-cycle fp32 adder: one shared mantissa datapath stepped through
// align, add and normalise, one bit-shift per cycle, truncating result.
module fp32_add_sequencer
  import fp32_pkg::*;
#(
  parameter int unsigned MAX_ALIGN = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Addend1,
  input  logic [31:0] Addend2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Sum,
  output logic        busy
);

  localparam logic [EXP_W-1:0] ALIGN_LIM = EXP_W'(MAX_ALIGN);

  seq_state_t        state, state_next;
  logic              sign_l, sign_s;
  logic [EXP_W-1:0]  exp_r, d_r;
  logic [MANT_W-1:0] mant_r, small_r;
  logic [31:0]       sum_r;
  logic              norm_done;

  logic              u_sign_l, u_sign_s;
  logic [EXP_W-1:0]  u_exp_l, u_d;
  logic [MANT_W-1:0] u_mant_l, u_mant_s;

  fp32_unpack u_unpack (
    .a      (Addend1),
    .b      (Addend2),
    .sign_l (u_sign_l),
    .sign_s (u_sign_s),
    .exp_l  (u_exp_l),
    .d      (u_d),
    .mant_l (u_mant_l),
    .mant_s (u_mant_s)
  );

  // NORM exits on carry, zero, hidden bit set, or a left shift that would hit exp 0.
  assign norm_done = mant_r[MANT_W-1] || mant_r[MANT_W-2] || (mant_r == '0) ||
                     (exp_r == EXP_W'(1));

  assign Sum = sum_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = ALIGN;
      end
      ALIGN:   if ((d_r == '0) || (d_r >= ALIGN_LIM)) state_next = ADD;
      ADD:     state_next = NORM;
      NORM:    if (norm_done) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_l  <= 1'b0;
      sign_s  <= 1'b0;
      exp_r   <= '0;
      d_r     <= '0;
      mant_r  <= '0;
      small_r <= '0;
      sum_r   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_l  <= u_sign_l;
          sign_s  <= u_sign_s;
          exp_r   <= u_exp_l;
          d_r     <= u_d;
          mant_r  <= u_mant_l;
          small_r <= u_mant_s;
        end
        ALIGN: if (d_r >= ALIGN_LIM) begin
          small_r <= '0;
        end else if (d_r != '0) begin
          small_r <= {1'b0, small_r[MANT_W-1:2], small_r[1] | small_r[0]};
          d_r     <= d_r - EXP_W'(1);
        end
        ADD: begin
          if (sign_l == sign_s) mant_r <= mant_r + small_r;
          else                  mant_r <= mant_r - small_r;
        end
        NORM: begin
          if (mant_r[MANT_W-1]) begin
            if (exp_r == EXP_MAX - EXP_W'(1)) sum_r <= {sign_l, EXP_MAX, 23'h0};
            else                             sum_r <= {sign_l, exp_r + EXP_W'(1), mant_r[25:3]};
          end else if (mant_r == '0) begin
            sum_r <= '0;
          end else if (mant_r[MANT_W-2]) begin
            sum_r <= {sign_l, exp_r, mant_r[24:2]};
          end else begin
            mant_r <= mant_r << 1;
            exp_r  <= exp_r - EXP_W'(1);
            if (exp_r == EXP_W'(1)) sum_r <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_add_sequencer.sv
// Scoreboard bench for fp32_add_sequencer: expected sums and latencies are
// queued when an operand pair is accepted and compared when Sum appears.
module tb_fp32_add_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Addend1;
  logic [31:0] Addend2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Sum;
  logic        busy;

  fp32_add_sequencer #(.MAX_ALIGN(25)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Addend1   (Addend1),
    .Addend2   (Addend2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] sum;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned accept_cyc;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // lat < 0 means the latency is not checked for that vector.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sum,
                      input int lat, input string tag);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    Addend1  = a;
    Addend2  = b;
    in_valid = 1'b1;
    e.sum = sum;
    e.lat = lat;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic collect(input int stall);
    exp_t        e;
    int          guard = 0;
    logic [31:0] held;
    out_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    e = sb.pop_front();
    if (!out_valid) begin
      check({e.tag, "_timeout"}, {31'b0, out_valid}, 32'd1);
      return;
    end
    check({e.tag, "_sum"}, Sum, e.sum);
    check({e.tag, "_busy"}, {31'b0, busy}, 32'd1);
    if (e.lat >= 0) check({e.tag, "_lat"}, cyc - accept_cyc, e.lat);
    held = Sum;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({e.tag, "_hold_sum"}, Sum, held);
      check({e.tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      check({e.tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({e.tag, "_post_valid"}, {31'b0, out_valid}, 32'd0);
    check({e.tag, "_post_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sum,
                    input int lat, input int stall, input string tag);
    send(a, b, sum, lat, tag);
    collect(stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Addend1   = '0;
    Addend2   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_sum", Sum, 32'h0);

    op(32'h3F800000, 32'h3F800000, 32'h40000000, 3, 0, "one_plus_one");
    op(32'h3FC00000, 32'hBFC00000, 32'h00000000, -1, 0, "cancel");
    op(32'h40400000, 32'hBF800000, 32'h40000000, 4, 0, "three_minus_one");
    op(32'hBF800000, 32'h40400000, 32'h40000000, 4, 0, "swapped");
    op(32'h3F800000, 32'h30800000, 32'h3F800000, 3, 0, "fast_path");
    op(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3, 0, "overflow_inf");
    op(32'h3F800000, 32'h3FC00000, 32'h40200000, 3, 0, "one_plus_1p5");
    op(32'h3FC00000, 32'hBFA00000, 32'h3E800000, 5, 0, "norm_left2");
    op(32'h00000000, 32'h3F800000, 32'h3F800000, 3, 0, "zero_plus_one");
    op(32'h00400000, 32'h3F800000, 32'h3F800000, 3, 0, "denorm_flush");
    op(32'h40400000, 32'hBF800000, 32'h40000000, 4, 5, "backpressure");

    // Abandon a d=20 operation mid-ALIGN with a one-cycle reset.
    @(negedge clk);
    Addend1  = 32'h3F800000;
    Addend2  = 32'h35800000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_sum", Sum, 32'h0);
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("midrst_no_output", stray, 32'd0);
    op(32'h3F800000, 32'h3F800000, 32'h40000000, 3, 0, "after_reset");

    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
